// File: rtl/radiant_scaler_pkg.sv
// radiant_scaler_pkg: shared constants and state type for the scaler snapshot readout
package radiant_scaler_pkg;
  localparam logic [7:0]  HDR_MAGIC    = 8'h5C;
  localparam logic [31:0] ERR_FILL     = 32'hFFFF_FFFF;
  localparam logic [15:0] DEF_BASE_ADR = 16'h0800;
  typedef enum logic [1:0] {IDLE, HDR, RD, PUSH} state_t;
endpackage

// File: rtl/radiant_scaler_readout.sv
// radiant_scaler_readout: on trigger, reads the scaler window over WISHBONE and streams a header plus data frame
module radiant_scaler_readout import radiant_scaler_pkg::*; #(
  parameter int          NUM_WORDS = 16,
  parameter logic [15:0] BASE_ADR  = DEF_BASE_ADR,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        trig_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [15:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [31:0] dat_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic [7:0]  overrun_o,
  output logic        err_o
);
  localparam int KW = $clog2(NUM_WORDS + 1);
  state_t      st_q;
  logic [KW-1:0] k_q;
  logic [7:0]  seq_q, tmr_q, ovr_q;
  logic [31:0] dat_q;
  logic [15:0] adr_q;
  logic        cyc_q, valid_q, last_q, err_q;
  logic        hs, fail;
  assign hs        = valid_q & ready_i;
  assign fail      = wbm_err_i | (tmr_q == 8'(TIMEOUT));
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;
  assign dat_o     = dat_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign busy_o    = st_q != IDLE;
  assign overrun_o = ovr_q;
  assign err_o     = err_q;
  // frame sequencer: header, then one read/push pair per scaler word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      k_q     <= '0;
      seq_q   <= '0;
      tmr_q   <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (trig_i && en_i) begin
          st_q    <= HDR;
          seq_q   <= seq_q + 8'd1;
          k_q     <= '0;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          dat_q   <= {HDR_MAGIC, seq_q + 8'd1, 16'(NUM_WORDS)};
        end
        HDR: if (hs) begin
          st_q    <= RD;
          valid_q <= 1'b0;
          cyc_q   <= 1'b1;
          adr_q   <= BASE_ADR;
          tmr_q   <= '0;
        end
        RD: if (fail || wbm_ack_i) begin
          st_q    <= PUSH;
          cyc_q   <= 1'b0;
          valid_q <= 1'b1;
          dat_q   <= fail ? ERR_FILL : wbm_dat_i;
          err_q   <= err_q | fail;
          last_q  <= k_q == KW'(NUM_WORDS - 1);
        end else begin
          tmr_q   <= tmr_q + 8'd1;
        end
        PUSH: if (hs) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (last_q) begin
            st_q  <= IDLE;
          end else begin
            st_q  <= RD;
            k_q   <= k_q + 1'b1;
            adr_q <= adr_q + 16'd4;
            cyc_q <= 1'b1;
            tmr_q <= '0;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  // saturating count of triggers that arrive while a frame is in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) ovr_q <= '0;
    else if (trig_i && busy_o && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
  end
endmodule
